// File: rtl/btn_pkg.sv
// Shared constants, encodings and helpers for the pushbutton conditioning front end.
package btn_pkg;

    localparam int unsigned NUM_BTNS = 5;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_D = 4;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_TIMER     = 2'd1,
        MODE_STOPWATCH = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Unreachable encodings fall back to the clock display.
    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            MODE_CLOCK: return MODE_TIMER;
            MODE_TIMER: return MODE_STOPWATCH;
            default:    return MODE_CLOCK;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce, edge pulses and auto-repeat FSM.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES         = 1000000,
    parameter int unsigned RPT_DELAY_CYCLES  = 50000000,
    parameter int unsigned RPT_PERIOD_CYCLES = 10000000,
    parameter bit          REPEAT_EN         = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int unsigned DB_W    = cnt_width(DB_CYCLES);
    localparam int unsigned RPT_MAX = (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ?
                                      RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
    localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(RPT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(RPT_PERIOD_CYCLES - 1);

    logic             r_sync1, r_sync2, r_stable;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_level, r_press, r_release, r_repeat;
    rpt_state_e       r_state;
    logic [RPT_W-1:0] r_rpt_cnt;

    logic             w_rise, w_fall, w_rpt_pulse, w_repeat_nxt;
    rpt_state_e       w_state_nxt;
    logic [RPT_W-1:0] w_rpt_cnt_nxt;

    // r_level trails r_stable by one cycle, so edges are detected one cycle
    // before they become visible and all outputs update together.
    assign w_rise = r_stable & ~r_level;
    assign w_fall = ~r_stable & r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stable  <= 1'b0;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_state   <= RPT_IDLE;
            r_rpt_cnt <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_stable) begin
                if (r_db_cnt == DB_LAST) begin
                    r_stable <= ~r_stable;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
            r_level   <= r_stable;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_repeat  <= w_repeat_nxt;
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
        end
    end

    // A release always returns to IDLE first, suppressing a coincident terminal count.
    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_rpt_pulse   = 1'b0;
        case (r_state)
            RPT_IDLE: begin
                if (w_rise) begin
                    w_rpt_pulse   = 1'b1;
                    w_rpt_cnt_nxt = '0;
                    w_state_nxt   = RPT_DELAY;
                end
            end
            RPT_DELAY: begin
                if (w_fall) begin
                    w_rpt_cnt_nxt = '0;
                    w_state_nxt   = RPT_IDLE;
                end else if (r_rpt_cnt == DLY_LAST) begin
                    w_rpt_pulse   = 1'b1;
                    w_rpt_cnt_nxt = '0;
                    w_state_nxt   = RPT_REPEAT;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
                end
            end
            RPT_REPEAT: begin
                if (w_fall) begin
                    w_rpt_cnt_nxt = '0;
                    w_state_nxt   = RPT_IDLE;
                end else if (r_rpt_cnt == PER_LAST) begin
                    w_rpt_pulse   = 1'b1;
                    w_rpt_cnt_nxt = '0;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
                end
            end
            default: begin
                w_rpt_cnt_nxt = '0;
                w_state_nxt   = RPT_IDLE;
            end
        endcase
        w_repeat_nxt = REPEAT_EN ? w_rpt_pulse : w_rise;
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_conditioner.sv
// Five conditioned pushbutton channels plus the BTNU-driven display-mode register.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES         = 1000000,
    parameter int unsigned RPT_DELAY_CYCLES  = 50000000,
    parameter int unsigned RPT_PERIOD_CYCLES = 10000000,
    parameter logic [4:0]  REPEAT_MASK       = 5'b11101
) (
    input  logic       clk_i,
    input  logic       reset_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic [4:0] btn_repeat,
    output logic [1:0] mode_o,
    output logic       mode_chg
);

    mode_e r_mode;
    logic  r_mode_chg;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES         (DB_CYCLES),
            .RPT_DELAY_CYCLES  (RPT_DELAY_CYCLES),
            .RPT_PERIOD_CYCLES (RPT_PERIOD_CYCLES),
            .REPEAT_EN         (REPEAT_MASK[g])
        ) u_ch (
            .i_clk     (clk_i),
            .i_rst     (reset_n),
            .i_raw     (btn_raw[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_repeat  (btn_repeat[g])
        );
    end

    // Only the true press pulse advances the mode, never auto-repeat.
    always_ff @(posedge clk_i) begin
        if (reset_n) begin
            r_mode     <= MODE_CLOCK;
            r_mode_chg <= 1'b0;
        end else begin
            r_mode_chg <= btn_press[BTN_U];
            if (btn_press[BTN_U]) begin
                r_mode <= next_mode(r_mode);
            end
        end
    end

    assign mode_o   = r_mode;
    assign mode_chg = r_mode_chg;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench: directed vector table plus randomized stimulus against a behavioural model.
module tb_btn_conditioner;

    localparam int DB  = 4;
    localparam int DLY = 20;
    localparam int PER = 8;
    localparam logic [4:0] MASK = 5'b11101;
    localparam int UBIT = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [1:0] mode_o;
    logic       mode_chg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DB_CYCLES         (DB),
        .RPT_DELAY_CYCLES  (DLY),
        .RPT_PERIOD_CYCLES (PER),
        .REPEAT_MASK       (MASK)
    ) dut (
        .clk_i       (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .mode_o      (mode_o),
        .mode_chg    (mode_chg)
    );

    // Model: a level is accepted once DB consecutive sampled raw values differ
    // from it; repeats are placed by arithmetic on the time held since the press.
    logic [4:0] m_hist [0:DB];
    logic [4:0] m_stable, m_level, m_press, m_release, m_repeat;
    int         m_age [5];
    int         m_mode;
    logic       m_chg;

    task automatic model_step(input logic rst, input logic [4:0] raw);
        logic [4:0] old_level;
        logic       all_diff;
        if (rst) begin
            for (int j = 0; j <= DB; j++) m_hist[j] = '0;
            m_stable = '0; m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
            for (int b = 0; b < 5; b++) m_age[b] = -1;
            m_mode = 0;
            m_chg  = 1'b0;
            return;
        end
        m_chg = m_press[UBIT];
        if (m_press[UBIT]) m_mode = (m_mode + 1) % 3;
        old_level = m_level;
        m_level   = m_stable;
        m_press   = m_level & ~old_level;
        m_release = ~m_level & old_level;
        for (int b = 0; b < 5; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DB; j++)
                if (m_hist[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) m_stable[b] = ~m_stable[b];
        end
        for (int j = DB; j >= 1; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = raw;
        for (int b = 0; b < 5; b++) begin
            if (m_press[b]) m_age[b] = 0;
            else if (m_level[b] && m_age[b] >= 0) m_age[b]++;
            else if (!m_level[b]) m_age[b] = -1;
            if (MASK[b])
                m_repeat[b] = (m_age[b] == 0) ||
                              (m_age[b] >= DLY && ((m_age[b] - DLY) % PER) == 0);
            else
                m_repeat[b] = m_press[b];
        end
    endtask

    task automatic check(input string name, input logic [4:0] lvl, input logic [4:0] prs,
                         input logic [4:0] rel, input logic [4:0] rep,
                         input logic [1:0] mode, input logic chg);
        total++;
        if ({btn_level, btn_press, btn_release, btn_repeat, mode_o, mode_chg} !==
            {lvl, prs, rel, rep, mode, chg}) begin
            bad++;
            $display("FAIL %s t=%0t got lvl=%b prs=%b rel=%b rep=%b mode=%0d chg=%b want lvl=%b prs=%b rel=%b rep=%b mode=%0d chg=%b",
                     name, $time, btn_level, btn_press, btn_release, btn_repeat, mode_o, mode_chg,
                     lvl, prs, rel, rep, mode, chg);
        end
    endtask

    task automatic step(input logic rst, input logic [4:0] raw);
        reset_n = rst;
        btn_raw = raw;
        @(posedge clk);
        #1;
        model_step(rst, raw);
        check("model", m_level, m_press, m_release, m_repeat, 2'(m_mode), m_chg);
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] raw;
        int         n;
        logic [4:0] lvl, prs, rel, rep;
        logic [1:0] mode;
        logic       chg;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic rst, input logic [4:0] raw, input int n,
                                input logic [4:0] lvl, input logic [4:0] prs,
                                input logic [4:0] rel, input logic [4:0] rep,
                                input logic [1:0] mode, input logic chg);
        vec_t v;
        v.rst = rst; v.raw = raw; v.n = n;
        v.lvl = lvl; v.prs = prs; v.rel = rel; v.rep = rep; v.mode = mode; v.chg = chg;
        return v;
    endfunction

    initial begin : main
        logic [4:0] raw;
        logic [1:0] mb, ma;
        int         hold [5];
        logic       rst;

        reset_n = 1'b1;
        btn_raw = '0;

        tbl.push_back(mk(1, 5'b00000, 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        // L press, first repeat, release just before the 28th-cycle repeat
        tbl.push_back(mk(0, 5'b00100, 6,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00100, 1,  5'b00100, 5'b00100, 5'b00000, 5'b00100, 0, 0));
        tbl.push_back(mk(0, 5'b00100, 1,  5'b00100, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00100, 18, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00100, 1,  5'b00100, 5'b00000, 5'b00000, 5'b00100, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 6,  5'b00100, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1,  5'b00000, 5'b00000, 5'b00100, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        // C glitch of 3 cycles rejected, 4-cycle pulse accepted
        tbl.push_back(mk(0, 5'b00001, 3,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 10, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00001, 4,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 2,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1,  5'b00001, 5'b00001, 5'b00000, 5'b00001, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 3,  5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1,  5'b00000, 5'b00000, 5'b00001, 5'b00000, 0, 0));
        // Four BTNU presses: mode 1, 2, 0, 1
        mb = 2'd0;
        for (int k = 0; k < 4; k++) begin
            ma = (mb == 2'd2) ? 2'd0 : mb + 2'd1;
            tbl.push_back(mk(0, 5'b00010, 6, 5'b00000, 5'b00000, 5'b00000, 5'b00000, mb, 0));
            tbl.push_back(mk(0, 5'b00010, 1, 5'b00010, 5'b00010, 5'b00000, 5'b00010, mb, 0));
            tbl.push_back(mk(0, 5'b00010, 1, 5'b00010, 5'b00000, 5'b00000, 5'b00000, ma, 1));
            tbl.push_back(mk(0, 5'b00000, 7, 5'b00000, 5'b00000, 5'b00010, 5'b00000, ma, 0));
            mb = ma;
        end
        // Long BTNU hold: one advance, no auto-repeat
        tbl.push_back(mk(0, 5'b00010, 6,   5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 0));
        tbl.push_back(mk(0, 5'b00010, 1,   5'b00010, 5'b00010, 5'b00000, 5'b00010, 1, 0));
        tbl.push_back(mk(0, 5'b00010, 1,   5'b00010, 5'b00000, 5'b00000, 5'b00000, 2, 1));
        tbl.push_back(mk(0, 5'b00010, 100, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 2, 0));
        tbl.push_back(mk(0, 5'b00000, 7,   5'b00000, 5'b00000, 5'b00010, 5'b00000, 2, 0));
        // D held into REPEAT, one-cycle reset, fresh press afterwards
        tbl.push_back(mk(0, 5'b10000, 6,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 2, 0));
        tbl.push_back(mk(0, 5'b10000, 1,  5'b10000, 5'b10000, 5'b00000, 5'b10000, 2, 0));
        tbl.push_back(mk(0, 5'b10000, 25, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 2, 0));
        tbl.push_back(mk(1, 5'b10000, 1,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b10000, 6,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b10000, 1,  5'b10000, 5'b10000, 5'b00000, 5'b10000, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 7,  5'b00000, 5'b00000, 5'b10000, 5'b00000, 0, 0));
        // C and R together, C released early while R keeps repeating
        tbl.push_back(mk(0, 5'b01001, 6,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b01001, 1,  5'b01001, 5'b01001, 5'b00000, 5'b01001, 0, 0));
        tbl.push_back(mk(0, 5'b01001, 19, 5'b01001, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b01001, 1,  5'b01001, 5'b00000, 5'b00000, 5'b01001, 0, 0));
        tbl.push_back(mk(0, 5'b01000, 6,  5'b01001, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b01000, 1,  5'b01000, 5'b00000, 5'b00001, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b01000, 1,  5'b01000, 5'b00000, 5'b00000, 5'b01000, 0, 0));
        tbl.push_back(mk(0, 5'b01000, 7,  5'b01000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b01000, 1,  5'b01000, 5'b00000, 5'b00000, 5'b01000, 0, 0));
        tbl.push_back(mk(0, 5'b01000, 16, 5'b01000, 5'b00000, 5'b00000, 5'b01000, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 6,  5'b01000, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1,  5'b00000, 5'b00000, 5'b01000, 5'b00000, 0, 0));

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) step(tbl[i].rst, tbl[i].raw);
            check($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel,
                  tbl[i].rep, tbl[i].mode, tbl[i].chg);
        end

        // Random per-button hold lengths mixing glitches and long holds, rare resets
        raw = '0;
        for (int b = 0; b < 5; b++) hold[b] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int b = 0; b < 5; b++) begin
                if (hold[b] == 0) begin
                    raw[b]  = 1'($urandom_range(0, 1));
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                          : int'($urandom_range(3, 70));
                end
                hold[b]--;
            end
            rst = ($urandom_range(0, 599) == 0);
            step(rst, raw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage that conditions the five raw board pushbuttons (C, U, L, R, D) before they reach the mode router and the clock, timer and stopwatch cores.
- Per button: synchronises, debounces, and produces one-cycle press/release pulses plus an auto-repeat pulse stream.
- Owns the display-mode register, which BTNU presses cycle clock → timer → stopwatch.
- Downstream logic consumes only clean single-cycle pulses and a registered mode value.

Parameters:
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms @ 100 MHz); must be ≥ 2.
- RPT_DELAY_CYCLES, 50000000, hold time after press before the first auto-repeat pulse (500 ms).
- RPT_PERIOD_CYCLES, 10000000, interval between subsequent auto-repeat pulses (100 ms).
- REPEAT_MASK, 5'b11101, per-button auto-repeat enable; bit 1 (U) is off by default.

Ports:
- clk_i  in  1  system clock, 100 MHz.
- reset_n  in  1  reset; **synchronous, active-high** despite the suffix.
- btn_raw  in  5  asynchronous button inputs: [0]=C, [1]=U, [2]=L, [3]=R, [4]=D.
- btn_level  out  5  debounced level per button.
- btn_press  out  5  one-cycle pulse on a debounced rising edge.
- btn_release  out  5  one-cycle pulse on a debounced falling edge.
- btn_repeat  out  5  press pulse plus auto-repeat pulses while held; equals btn_press where REPEAT_MASK bit is 0.
- mode_o  out  2  0 = clock, 1 = timer, 2 = stopwatch.
- mode_chg  out  1  one-cycle pulse in the cycle mode_o updates.

Behaviour:
- Reset: all outputs 0. Synchroniser flops, stable levels, debounce counters and repeat counters cleared. Repeat FSMs go to IDLE. mode_o = 0.
- Synchroniser: two flops per button; sync = second flop.
- Debounce, per button:
  - If sync != stable, counter increments; otherwise counter clears to 0.
  - When counter == DB_CYCLES-1 and sync != stable still holds, stable toggles and counter clears.
  - Any glitch shorter than DB_CYCLES cycles is rejected, with the counter restarting from 0.
- Latency: a raw edge that persists has btn_level change exactly 2 + DB_CYCLES cycles after the first clk_i edge that samples it.
- btn_press and btn_release are registered and assert in the same cycle btn_level changes, for exactly one cycle.
- Repeat FSM, per masked button:
  - IDLE: on press, pulse btn_repeat, clear counter, go to DELAY.
  - DELAY: count; when counter == RPT_DELAY_CYCLES-1, pulse btn_repeat, clear counter, go to REPEAT.
  - REPEAT: when counter == RPT_PERIOD_CYCLES-1, pulse btn_repeat and clear counter.
  - Release in DELAY or REPEAT: return to IDLE immediately; no pulse in the release cycle.
  - Release and counter terminal in the same cycle: release wins, no pulse.
- Mode:
  - On btn_press[1], mode_o advances 0→1→2→0 and mode_chg pulses.
  - Value 3 is unreachable; if ever present, the next press loads 0.
  - Auto-repeat never advances mode, even if REPEAT_MASK[1] = 1.
- Simultaneous presses: every channel is independent; all pulses may assert in the same cycle.
- Reset while a button is held:
  - All state clears and the level returns to 0.
  - After reset deasserts, the held button produces a fresh press after 2 + DB_CYCLES cycles.
- Counter widths are $clog2 of the largest relevant parameter; no counter wraps before its terminal compare.

Decomposition:
- Package btn_pkg:
  - Button index constants BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4.
  - Mode encodings MODE_CLOCK=2'd0, MODE_TIMER=2'd1, MODE_STOPWATCH=2'd2.
- Sub-module btn_debounce_ch:
  - Holds one channel: synchroniser, debounce counter, level, press/release, and the repeat FSM with a REPEAT_EN parameter.
  - Instanced five times via generate.
- The top of this block adds only the mode register.

Test Plan:
All scenarios run with DB_CYCLES=4, RPT_DELAY_CYCLES=20, RPT_PERIOD_CYCLES=8.
1. btn_raw[2] rises and holds → btn_level[2] and btn_press[2] rise 6 cycles later; btn_press[2] lasts 1 cycle.
2. btn_raw[0] pulses high for 3 cycles, then low → no level change and no pulses. A 4-cycle-stable pulse → press pulse; release pulse 6 cycles after the falling edge.
3. btn_raw[3] held 60 cycles after acceptance → btn_repeat[3] pulses at relative cycles 0, 20, 28, 36, 44, 52. Releasing at cycle 27 (debounced) → no pulse at 28.
4. Four separated BTNU presses → mode_o goes 1, 2, 0, 1 with one mode_chg each. Holding BTNU 100 cycles → exactly one advance and btn_repeat[1] = btn_press[1].
5. Hold btn_raw[4], assert reset_n mid-REPEAT for 1 cycle → all outputs 0 and mode_o = 0 next cycle. New press 6 cycles after release of reset.
6. Press C and R in the same cycle → both press pulses coincide; each repeat stream is independently timed.
